// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: captures CPU stores to IO_ADDR in a FIFO and sends them as 8N1.
// Define MMIO_UART_TX_PARITY_EN to add an even parity bit (11-bit frame).
module mmio_uart_tx #(
  parameter logic [15:0] IO_ADDR      = 16'hFF00,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr_bus,
  input  logic [7:0]  data_bus,
  input  logic        mem_w,
  input  logic        mem_r,
  output logic [7:0]  rdata,
  output logic        rdata_oe,
  output logic        tx,
  output logic        busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CMAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0] ST_ADDR = 16'(IO_ADDR + 16'd1);

`ifdef MMIO_UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t state, state_n;

  logic          mem_w_q, mem_r_q;
  logic          push, rd_rise, pop, accept;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          empty, full, ovf;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shifter, shifter_n;
  logic          bit_end, tx_d;
`ifdef MMIO_UART_TX_PARITY_EN
  logic          par_q, par_n;
`endif

  assign push    = mem_w && !mem_w_q && (addr_bus == IO_ADDR);
  assign rd_rise = mem_r && !mem_r_q && (addr_bus == ST_ADDR);
  assign empty   = (count == '0);
  assign full    = (count == DEPTH);
  // A full FIFO still takes a byte when a pop frees a slot on the same edge.
  assign accept  = push && (!full || pop);
  assign bit_end = (cnt == CMAX);

  assign busy     = (state != IDLE) || !empty;
  assign rdata_oe = mem_r && (addr_bus == ST_ADDR);
  assign rdata    = rdata_oe ? {4'b0, ovf, state != IDLE, full, empty} : 8'h00;

  // Strobe edge detectors, FIFO pointers/count and the sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_w_q <= 1'b0;
      mem_r_q <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf     <= 1'b0;
    end else begin
      mem_w_q <= mem_w;
      mem_r_q <= mem_r;
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      if (pop)    rd_ptr <= rd_ptr + AW'(1);
      if (accept && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !accept) count <= count - (AW+1)'(1);
      if (push && full && !pop) ovf <= 1'b1;
      else if (rd_rise)         ovf <= 1'b0;
    end
  end

  // FIFO storage; contents are only meaningful behind the pointers.
  always_ff @(posedge clk) begin
    if (accept) fifo_mem[wr_ptr] <= data_bus;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state logic; pop fires on leaving IDLE or STOP with data waiting.
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          state_n = START;
          pop     = 1'b1;
        end
      end
      START: if (bit_end) state_n = DATA;
      DATA: begin
        if (bit_end && idx == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
          state_n = PARITY;
`else
          state_n = STOP;
`endif
        end
      end
`ifdef MMIO_UART_TX_PARITY_EN
      PARITY: if (bit_end) state_n = STOP;
`endif
      STOP: begin
        if (bit_end) begin
          if (!empty) begin
            state_n = START;
            pop     = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Next values for baud counter, bit index and shifter.
  always_comb begin
    shifter_n = shifter;
    cnt_n     = cnt;
    idx_n     = idx;
    if (pop) begin
      shifter_n = fifo_mem[rd_ptr];
      cnt_n     = '0;
      idx_n     = '0;
    end else if (state != IDLE) begin
      cnt_n = bit_end ? '0 : cnt + 1'b1;
      if (state == DATA && bit_end) begin
        shifter_n = {1'b0, shifter[7:1]};
        idx_n     = idx + 3'd1;
      end
    end
  end

`ifdef MMIO_UART_TX_PARITY_EN
  assign par_n = pop ? ^fifo_mem[rd_ptr] : par_q;
`endif

  // Line level for the coming cycle, taken from the next state.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_n)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shifter_n[0];
`ifdef MMIO_UART_TX_PARITY_EN
      PARITY:  tx_d = par_n;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  // Datapath registers; tx is registered so the line never glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      idx     <= '0;
      shifter <= '0;
      tx      <= 1'b1;
`ifdef MMIO_UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      cnt     <= cnt_n;
      idx     <= idx_n;
      shifter <= shifter_n;
      tx      <= tx_d;
`ifdef MMIO_UART_TX_PARITY_EN
      par_q   <= par_n;
`endif
    end
  end

endmodule
